// File: rtl/dp_sram_mem_pkg.sv
// mem_pkg: shared constants, response record and address check for dp_sram_mem
package mem_pkg;
    localparam int BYTE_W     = 8;
    localparam int MAX_RD_LAT = 4;
    localparam int MAX_DATA_W = 128;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MAX_DATA_W-1:0] data;
    } resp_t;

    // word-aligned and below the byte size of the array
    function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] depth_b);
        return (addr[1:0] == 2'b00) && (addr < depth_b);
    endfunction
endpackage

// File: rtl/dp_sram_mem_if.sv
// dp_sram_mem_if: fetch (A) and load/store (B) request/response bus of dp_sram_mem
interface dp_sram_mem_if import mem_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     a_req_i;
    logic                     a_gnt_o;
    logic [ADDR_W-1:0]        a_addr_i;
    logic                     a_rvalid_o;
    logic [DATA_W-1:0]        a_rdata_o;
    logic                     a_err_o;
    logic                     b_req_i;
    logic                     b_gnt_o;
    logic                     b_we_i;
    logic [DATA_W/BYTE_W-1:0] b_be_i;
    logic [ADDR_W-1:0]        b_addr_i;
    logic [DATA_W-1:0]        b_wdata_i;
    logic                     b_rvalid_o;
    logic [DATA_W-1:0]        b_rdata_o;
    logic                     b_err_o;

    modport master (
        output a_req_i, a_addr_i, b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o, b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o
    );

    modport slave (
        input  a_req_i, a_addr_i, b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o, b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o
    );
endinterface

// File: rtl/dp_sram_mem_rd_pipe.sv
// mem_rd_pipe: extra response register stages after the array read stage
module mem_rd_pipe import mem_pkg::*; #(
    parameter int STAGES = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t i_resp,
    output resp_t o_resp
);
    localparam int N = (STAGES > 0) ? STAGES : 1;

    resp_t r_q [N];

    // shift responses forward in order; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) r_q[i] <= '0;
        end else begin
            r_q[0] <= i_resp;
            for (int i = 1; i < N; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign o_resp = (STAGES > 0) ? r_q[N-1] : i_resp;
endmodule

// File: rtl/dp_sram_mem.sv
// dp_sram_mem: dual-port word memory, A fetch / B load-store; MEM_PARITY_EN adds per-byte parity
module dp_sram_mem import mem_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef MEM_PARITY_EN
    input  logic inj_par_i,
`endif
    dp_sram_mem_if.slave bus
);
    localparam int          NB  = DATA_W / BYTE_W;
    localparam int          IW  = $clog2(DEPTH);
    localparam logic [63:0] LIM = 64'(DEPTH) * 64'(NB);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_a_addr, w_b_addr;
    logic [IW-1:0]     w_a_idx, w_b_idx;
    logic              w_a_ok, w_b_ok, w_b_wr;
    logic              r_a_vld, r_a_rd, r_b_vld, r_b_aerr, r_b_ld;
    logic [DATA_W-1:0] r_a_dat, r_b_dat;
    logic              w_a_perr, w_b_perr;
    resp_t             w_a_s1, w_b_s1, w_a_out, w_b_out;
    logic              w_unused;

    assign w_a_addr     = bus.a_addr_i;
    assign w_b_addr     = bus.b_addr_i;
    assign w_a_idx      = w_a_addr[IW+1:2];
    assign w_b_idx      = w_b_addr[IW+1:2];
    assign w_a_ok       = addr_ok(64'(w_a_addr), LIM);
    assign w_b_ok       = addr_ok(64'(w_b_addr), LIM);
    assign bus.a_gnt_o  = bus.a_req_i && rst;
    assign bus.b_gnt_o  = bus.b_req_i && rst;
    assign w_b_wr       = bus.b_gnt_o && bus.b_we_i && w_b_ok;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] r_a_par, r_b_par;

    // even parity per written byte; inj_par_i flips it to plant faults
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (w_b_wr && bus.b_be_i[k])
                r_par[w_b_idx][k] <= (^bus.b_wdata_i[k*BYTE_W +: BYTE_W]) ^ inj_par_i;
    end

    // parity read alongside the data word
    always_ff @(posedge clk) begin
        r_a_par <= r_par[w_a_idx];
        r_b_par <= r_par[w_b_idx];
    end

    // any byte whose data no longer matches its stored parity
    always_comb begin
        w_a_perr = 1'b0;
        w_b_perr = 1'b0;
        for (int k = 0; k < NB; k++) begin
            w_a_perr = w_a_perr | ((^r_a_dat[k*BYTE_W +: BYTE_W]) ^ r_a_par[k]);
            w_b_perr = w_b_perr | ((^r_b_dat[k*BYTE_W +: BYTE_W]) ^ r_b_par[k]);
        end
    end
`else
    assign w_a_perr = 1'b0;
    assign w_b_perr = 1'b0;
`endif

    // byte-granular store from port B, committed at the edge ending the accept cycle
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (w_b_wr && bus.b_be_i[k])
                r_mem[w_b_idx][k*BYTE_W +: BYTE_W] <= bus.b_wdata_i[k*BYTE_W +: BYTE_W];
    end

    // synchronous read of both ports; sees the pre-store word (read-first)
    always_ff @(posedge clk) begin
        r_a_dat <= r_mem[w_a_idx];
        r_b_dat <= r_mem[w_b_idx];
    end

    // first response stage: which accepted accesses return data or an address fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_vld  <= 1'b0;
            r_a_rd   <= 1'b0;
            r_b_vld  <= 1'b0;
            r_b_aerr <= 1'b0;
            r_b_ld   <= 1'b0;
        end else begin
            r_a_vld  <= bus.a_gnt_o;
            r_a_rd   <= bus.a_gnt_o && w_a_ok;
            r_b_vld  <= bus.b_gnt_o;
            r_b_aerr <= bus.b_gnt_o && !w_b_ok;
            r_b_ld   <= bus.b_gnt_o && !bus.b_we_i && w_b_ok;
        end
    end

    // build stage-one responses; faulted accesses and stores return zero data
    always_comb begin
        w_a_s1       = '0;
        w_a_s1.valid = r_a_vld;
        w_a_s1.err   = (r_a_vld && !r_a_rd) || (r_a_rd && w_a_perr);
        w_a_s1.data  = r_a_rd ? MAX_DATA_W'(r_a_dat) : '0;
        w_b_s1       = '0;
        w_b_s1.valid = r_b_vld;
        w_b_s1.err   = r_b_aerr || (r_b_ld && w_b_perr);
        w_b_s1.data  = r_b_ld ? MAX_DATA_W'(r_b_dat) : '0;
    end

    mem_rd_pipe #(.STAGES(RD_LAT-1)) u_a_pipe (.clk(clk), .rst(rst), .i_resp(w_a_s1), .o_resp(w_a_out));
    mem_rd_pipe #(.STAGES(RD_LAT-1)) u_b_pipe (.clk(clk), .rst(rst), .i_resp(w_b_s1), .o_resp(w_b_out));

    assign bus.a_rvalid_o = w_a_out.valid;
    assign bus.a_err_o    = w_a_out.err;
    assign bus.a_rdata_o  = w_a_out.data[DATA_W-1:0];
    assign bus.b_rvalid_o = w_b_out.valid;
    assign bus.b_err_o    = w_b_out.err;
    assign bus.b_rdata_o  = w_b_out.data[DATA_W-1:0];
    assign w_unused       = ^{w_a_out.data, w_b_out.data};
endmodule

// File: tb/tb_dp_sram_mem.sv
// tb_dp_sram_mem: directed + random stimulus against a word-array reference model
module tb_dp_sram_mem;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4096;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inj = 1'b0;
    logic [31:0] mm   [DEPTH];
    logic [3:0]  pbad [DEPTH];
    exp_t        qa[$], qb[$];
    int          cyc = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    dp_sram_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dp_sram_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MEM_PARITY_EN
        .inj_par_i(inj),
`endif
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit okf(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int sel = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, 63));
        if (sel == 0) return {w[29:0], 2'($urandom_range(1, 3))};
        if (sel == 1) return 32'h4000 + (w << 2);
        return w << 2;
    endfunction

    // one clock cycle: drive, predict, advance, check responses due now
    task automatic step(input bit ar, input logic [31:0] aa, input bit br, input bit bw,
                        input logic [3:0] be, input logic [31:0] ba, input logic [31:0] bd);
        exp_t e;
        bit   r0 = rst;
        bus.a_req_i = ar; bus.a_addr_i = aa;
        bus.b_req_i = br; bus.b_we_i = bw; bus.b_be_i = be; bus.b_addr_i = ba; bus.b_wdata_i = bd;
        #1;
        chk("a_gnt", 32'(bus.a_gnt_o), 32'(ar && r0));
        chk("b_gnt", 32'(bus.b_gnt_o), 32'(br && r0));
        if (!r0) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ar) begin
                e.due = cyc + RD_LAT;
                e.d   = okf(aa) ? mm[aa[13:2]] : 32'h0;
                e.e   = !okf(aa) || (pbad[aa[13:2]] != 4'h0);
                qa.push_back(e);
            end
            if (br) begin
                e.due = cyc + RD_LAT;
                e.d   = (okf(ba) && !bw) ? mm[ba[13:2]] : 32'h0;
                e.e   = !okf(ba) || (!bw && pbad[ba[13:2]] != 4'h0);
                qb.push_back(e);
                if (okf(ba) && bw)
                    for (int k = 0; k < 4; k++)
                        if (be[k]) begin
                            mm[ba[13:2]][k*8 +: 8] = bd[k*8 +: 8];
                            pbad[ba[13:2]][k]      = inj;
                        end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            chk("a_rvalid", 32'(bus.a_rvalid_o), 32'd1);
            chk("a_rdata", bus.a_rdata_o, e.d);
            chk("a_err", 32'(bus.a_err_o), 32'(e.e));
        end else begin
            chk("a_rvalid_idle", 32'(bus.a_rvalid_o), 32'd0);
            if (!r0) chk("a_rdata_rst", bus.a_rdata_o, 32'h0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            chk("b_rvalid", 32'(bus.b_rvalid_o), 32'd1);
            chk("b_rdata", bus.b_rdata_o, e.d);
            chk("b_err", 32'(bus.b_err_o), 32'(e.e));
        end else begin
            chk("b_rvalid_idle", 32'(bus.b_rvalid_o), 32'd0);
            if (!r0) chk("b_rdata_rst", bus.b_rdata_o, 32'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) pbad[i] = 4'h0;
        // reset held with both ports requesting
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 32'h0, 1, 0, 4'hf, 32'h0, 32'h0);
        rst = 1'b1;
        // fill the working window so every later read has a known value
        for (int w = 0; w < 64; w++) step(0, 0, 1, 1, 4'hf, 32'(w * 4), $urandom);
        idle(RD_LAT);
        // byte-strobe merge
        step(0, 0, 1, 1, 4'hf, 32'h10, 32'hDEADBEEF);
        step(0, 0, 1, 1, 4'h1, 32'h10, 32'h000000AA);
        step(1, 32'h10, 0, 0, 4'h0, 0, 0);
        idle(RD_LAT);
        // read-first collision, then new value visible next cycle
        step(0, 0, 1, 1, 4'hf, 32'h20, 32'h22222222);
        step(1, 32'h20, 1, 1, 4'hf, 32'h20, 32'h11111111);
        step(1, 32'h20, 1, 0, 4'hf, 32'h20, 32'h0);
        idle(RD_LAT);
        // address faults leave memory alone
        step(1, 32'h4000, 1, 1, 4'hf, 32'h06, 32'hFFFFFFFF);
        step(1, 32'h04, 1, 0, 4'hf, 32'h4001, 32'h0);
        step(1, 32'h07, 1, 0, 4'hf, 32'h04, 32'h0);
        // empty strobe store
        step(0, 0, 1, 1, 4'h0, 32'h30, 32'h5A5A5A5A);
        step(1, 32'h30, 0, 0, 4'h0, 0, 0);
        idle(RD_LAT);
        // back-to-back fetches
        step(1, 32'h0, 0, 0, 4'h0, 0, 0);
        step(1, 32'h4, 0, 0, 4'h0, 0, 0);
        step(1, 32'h8, 0, 0, 4'h0, 0, 0);
        idle(RD_LAT);
        // random traffic on both ports
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_addr(), $urandom);
        idle(RD_LAT);
        // reset mid-stream: in-flight responses vanish, preceding store still lands
        step(1, 32'h0, 1, 1, 4'hf, 32'h40, 32'hCAFEF00D);
        step(1, 32'h4, 0, 0, 4'h0, 0, 0);
        rst = 1'b0;
        step(1, 32'h8, 1, 0, 4'hf, 32'h40, 0);
        step(1, 32'hC, 0, 0, 4'h0, 0, 0);
        rst = 1'b1;
        idle(RD_LAT + 2);
        step(1, 32'h40, 1, 0, 4'hf, 32'h40, 0);
        idle(RD_LAT);
`ifdef MEM_PARITY_EN
        // planted parity fault reported alongside the stored data
        inj = 1'b1;
        step(0, 0, 1, 1, 4'hf, 32'h50, 32'h12345678);
        inj = 1'b0;
        step(1, 32'h50, 1, 0, 4'hf, 32'h50, 0);
        step(0, 0, 1, 1, 4'hf, 32'h50, 32'h12345678);
        step(1, 32'h50, 1, 0, 4'hf, 32'h50, 0);
        idle(RD_LAT);
`endif
        chk("a_drained", 32'(qa.size()), 32'd0);
        chk("b_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
